fetch_group_sender: RTL and testbench

- Producer side of the ibuffer fill interface.
- Holds the fetch PC and answers each fetch_inst request pulse from the ibuffer by issuing one 16-byte aligned icache access.
- Delivers the returned line as a lane-0-aligned group of up to 4 instructions, with a valid mask, group PC and prediction fields.
- Handles redirects, including discarding any icache response still in flight.

---
 rtl/fetch_group_sender_pkg.sv | 22 ++
 rtl/fetch_predecode.sv | 57 +++++
 rtl/fetch_group_sender.sv | 151 +++++++++++++++
 tb/tb_fetch_group_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_group_sender_pkg.sv
// Shared definitions for the fetch group sender: FSM encoding, group geometry and predecode opcodes.
package fetch_group_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  localparam int GROUP_WORDS = 4;
  localparam int FETCH_BYTES = 16;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Lanes that still hold real words once the line is shifted down by off words.
  function automatic logic [GROUP_WORDS-1:0] lane_mask(input logic [1:0] off);
    return 4'b1111 >> off;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Per-lane backward-branch / JAL detection for a lane-0-aligned fetch group; keeps only the first taken lane.
module fetch_predecode
  import fetch_group_sender_pkg::*;
(
  input  logic [63:0]  group_pc,
  input  logic [127:0] instr,
  input  logic [3:0]   valid_in,
  output logic [3:0]   valid_out,
  output logic [3:0]   taken,
  output logic [127:0] target,
  output logic         any_taken,
  output logic [63:0]  redirect_pc
);

  logic [3:0]       hit;
  logic [3:0][63:0] lane_target;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [31:0] word;
      logic [63:0] lane_pc;
      logic [63:0] b_imm;
      logic [63:0] j_imm;
      logic        is_bwd_branch;
      logic        is_jal;

      assign word          = instr[32*gi +: 32];
      assign lane_pc       = group_pc + 64'(gi * 4);
      assign b_imm         = {{52{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
      assign j_imm         = {{44{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
      // A branch is only predicted taken when its offset is negative (bit 31 is the imm sign).
      assign is_bwd_branch = (word[6:0] == OPC_BRANCH) && word[31];
      assign is_jal        = (word[6:0] == OPC_JAL);
      assign hit[gi]       = valid_in[gi] && (is_bwd_branch || is_jal);
      assign lane_target[gi] = lane_pc + (is_jal ? j_imm : b_imm);
    end
  endgenerate

  always_comb begin
    valid_out   = valid_in;
    taken       = '0;
    target      = '0;
    any_taken   = 1'b0;
    redirect_pc = '0;
    for (int i = 0; i < 4; i++) begin
      if (any_taken) begin
        valid_out[i] = 1'b0;
      end else if (hit[i]) begin
        any_taken          = 1'b1;
        taken[i]           = 1'b1;
        target[32*i +: 32] = lane_target[i][31:0];
        redirect_pc        = lane_target[i];
      end
    end
  end

endmodule

// File: rtl/fetch_group_sender.sv
// Ibuffer fill producer: one aligned icache access per request, delivered as a lane-0-aligned group.
// Optional BTFN prediction is enabled by defining FETCH_BTFN_PREDICT_EN.
module fetch_group_sender #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int          GROUP_WORDS = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         fetch_inst,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_target,
  output logic         pc_index_valid,
  output logic [63:0]  pc_index,
  input  logic         pc_index_ready,
  input  logic         icache_resp_valid,
  input  logic [127:0] icache_resp_data,
  output logic         pc_operation_done,
  output logic [127:0] admin2ib_instr,
  output logic [3:0]   admin2ib_instr_valid,
  output logic [63:0]  pc,
  output logic [3:0]   admin2ib_predicttaken,
  output logic [127:0] admin2ib_predicttarget
);

  import fetch_group_sender_pkg::*;

  fetch_state_e state_reg;
  logic [63:0]  fetch_pc_reg;
  logic         req_pending_reg;
  logic [1:0]   off_reg;
  logic         done_reg;
  logic [3:0]   valid_reg;
  logic [127:0] instr_reg;
  logic [63:0]  pc_reg;
  logic [3:0]   taken_reg;
  logic [127:0] target_reg;

  logic         accept;
  logic         deliver;
  logic [127:0] shifted;
  logic [3:0]   base_valid;
  logic [63:0]  seq_pc;
  logic [3:0]   grp_valid;
  logic [3:0]   grp_taken;
  logic [127:0] grp_target;
  logic [63:0]  next_pc;

  assign accept     = (state_reg == ST_REQ) && pc_index_ready;
  assign deliver    = (state_reg == ST_WAIT) && icache_resp_valid && !redirect_valid;
  assign shifted    = icache_resp_data >> {off_reg, 5'b0};
  assign base_valid = lane_mask(off_reg);
  assign seq_pc     = {fetch_pc_reg[63:4], 4'b0} + 64'(FETCH_BYTES);

`ifdef FETCH_BTFN_PREDICT_EN
  logic        pred_hit;
  logic [63:0] pred_pc;

  fetch_predecode u_predecode (
    .group_pc    (fetch_pc_reg),
    .instr       (shifted),
    .valid_in    (base_valid),
    .valid_out   (grp_valid),
    .taken       (grp_taken),
    .target      (grp_target),
    .any_taken   (pred_hit),
    .redirect_pc (pred_pc)
  );

  assign next_pc = pred_hit ? pred_pc : seq_pc;
`else
  assign grp_valid  = base_valid;
  assign grp_taken  = '0;
  assign grp_target = '0;
  assign next_pc    = seq_pc;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      fetch_pc_reg    <= RESET_PC;
      req_pending_reg <= 1'b0;
      off_reg         <= 2'b0;
      done_reg        <= 1'b0;
      valid_reg       <= '0;
      instr_reg       <= '0;
      pc_reg          <= RESET_PC;
      taken_reg       <= '0;
      target_reg      <= '0;
    end else begin
      done_reg  <= 1'b0;
      valid_reg <= '0;

      // A request arriving on the accept edge is a fresh one and survives the clear.
      if (redirect_valid)  req_pending_reg <= 1'b0;
      else if (fetch_inst) req_pending_reg <= 1'b1;
      else if (accept)     req_pending_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (!redirect_valid && (req_pending_reg || fetch_inst)) state_reg <= ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            state_reg <= pc_index_ready ? ST_KILL : ST_IDLE;
          end else if (pc_index_ready) begin
            state_reg <= ST_WAIT;
            off_reg   <= fetch_pc_reg[3:2];
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            state_reg <= icache_resp_valid ? ST_IDLE : ST_KILL;
          end else if (icache_resp_valid) begin
            state_reg  <= ST_IDLE;
            done_reg   <= 1'b1;
            valid_reg  <= grp_valid;
            instr_reg  <= shifted;
            pc_reg     <= fetch_pc_reg;
            taken_reg  <= grp_taken;
            target_reg <= grp_target;
          end
        end
        ST_KILL: begin
          if (icache_resp_valid) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (redirect_valid)  fetch_pc_reg <= redirect_target & ~64'd3;
      else if (deliver)    fetch_pc_reg <= next_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (GROUP_WORDS == fetch_group_sender_pkg::GROUP_WORDS)
        else $error("fetch_group_sender: GROUP_WORDS must be 4");
    end
  end

  assign pc_index_valid         = (state_reg == ST_REQ);
  assign pc_index               = pc_index_valid ? {fetch_pc_reg[63:4], 4'b0} : 64'b0;
  // The ibuffer flushes on redirect, so a group landing in that cycle is suppressed as well.
  assign admin2ib_instr_valid   = valid_reg & {4{~redirect_valid}};
  assign pc_operation_done      = done_reg & ~redirect_valid;
  assign admin2ib_instr         = instr_reg;
  assign pc                     = pc_reg;
  assign admin2ib_predicttaken  = taken_reg;
  assign admin2ib_predicttarget = target_reg;

endmodule

// File: tb/tb_fetch_group_sender.sv
// Self-checking bench for fetch_group_sender: directed scenarios plus randomized traffic against a flag-based model.
module tb_fetch_group_sender;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         fetch_inst = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [63:0]  redirect_target = '0;
  logic         pc_index_valid;
  logic [63:0]  pc_index;
  logic         pc_index_ready = 1'b0;
  logic         icache_resp_valid = 1'b0;
  logic [127:0] icache_resp_data = '0;
  logic         pc_operation_done;
  logic [127:0] admin2ib_instr;
  logic [3:0]   admin2ib_instr_valid;
  logic [63:0]  pc;
  logic [3:0]   admin2ib_predicttaken;
  logic [127:0] admin2ib_predicttarget;

  fetch_group_sender #(.RESET_PC(RESET_PC), .GROUP_WORDS(4)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .fetch_inst             (fetch_inst),
    .redirect_valid         (redirect_valid),
    .redirect_target        (redirect_target),
    .pc_index_valid         (pc_index_valid),
    .pc_index               (pc_index),
    .pc_index_ready         (pc_index_ready),
    .icache_resp_valid      (icache_resp_valid),
    .icache_resp_data       (icache_resp_data),
    .pc_operation_done      (pc_operation_done),
    .admin2ib_instr         (admin2ib_instr),
    .admin2ib_instr_valid   (admin2ib_instr_valid),
    .pc                     (pc),
    .admin2ib_predicttaken  (admin2ib_predicttaken),
    .admin2ib_predicttarget (admin2ib_predicttarget)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: m_pc is the next fetch address; the flags describe the single request's life.
  logic [63:0]  m_pc, m_out_pc;
  logic         m_want, m_asking, m_flight, m_drop;
  logic         m_dlv;
  logic [3:0]   m_valid, m_taken;
  logic [127:0] m_instr, m_target;
  logic         prev_valid;

  // Icache responder: replies next_lat cycles after each accepted request.
  int           resp_timer = 0;
  int           next_lat = 1;
  logic         use_fixed = 1'b0;
  logic [127:0] fixed_data = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_out_pc = RESET_PC;
    m_want = 0; m_asking = 0; m_flight = 0; m_drop = 0; m_dlv = 0;
    m_valid = '0; m_taken = '0; m_instr = '0; m_target = '0;
    prev_valid = 0; resp_timer = 0;
  endtask

  // Group contents from the line: words at and after the fetch PC, moved down to lane 0.
  task automatic model_deliver(input logic [127:0] data);
    int          off, cnt;
    logic [63:0] nxt;
`ifdef FETCH_BTFN_PREDICT_EN
    logic [31:0] w;
    logic [12:0] bi;
    logic [20:0] ji;
    logic [63:0] imm, tgt;
    logic        found;
`endif
    off = int'(m_pc[3:2]);
    cnt = 4 - off;
    m_instr = '0; m_taken = '0; m_target = '0;
    for (int i = 0; i < cnt; i++) m_instr[32*i +: 32] = data[32*(off+i) +: 32];
    nxt = m_pc + 64'(4 * cnt);
`ifdef FETCH_BTFN_PREDICT_EN
    found = 0;
    for (int i = 0; i < 4; i++) begin
      if (!found && i < cnt) begin
        w  = m_instr[32*i +: 32];
        bi = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        ji = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        imm = (w[6:0] == 7'b1101111) ? {{43{ji[20]}}, ji} : {{51{bi[12]}}, bi};
        if ((w[6:0] == 7'b1100011 && w[31]) || w[6:0] == 7'b1101111) begin
          found = 1;
          tgt = m_pc + 64'(4 * i) + imm;
          m_taken[i] = 1'b1;
          m_target[32*i +: 32] = tgt[31:0];
          nxt = tgt;
          cnt = i + 1;
        end
      end
    end
`endif
    m_valid  = 4'((1 << cnt) - 1);
    m_out_pc = m_pc;
    m_pc     = nxt;
    m_dlv    = 1;
  endtask

  task automatic cycle(input logic fi, input logic rv, input logic [63:0] rt, input logic rdy);
    logic         acc, resp;
    logic [3:0]   ev;
    logic [127:0] data;
    @(negedge clock);
    fetch_inst = fi; redirect_valid = rv; redirect_target = rt; pc_index_ready = rdy;
    resp = (resp_timer == 1);
    data = use_fixed ? fixed_data : {$urandom(), $urandom(), $urandom(), $urandom()};
    icache_resp_valid = resp;
    icache_resp_data  = data;
    #1;
    ev = (m_dlv && !rv) ? m_valid : 4'b0;
    check("pc_index_valid", pc_index_valid, m_asking);
    check("pc_index", pc_index, m_asking ? {m_pc[63:4], 4'b0} : 64'b0);
    check("instr_valid", admin2ib_instr_valid, ev);
    check("done", pc_operation_done, m_dlv && !rv);
    check("pc", pc, m_out_pc);
    check("pulse_width", |admin2ib_instr_valid && prev_valid, 1'b0);
    if (m_dlv) begin
      check("instr", admin2ib_instr, m_instr);
      check("predicttaken", admin2ib_predicttaken, m_taken);
      check("predicttarget", admin2ib_predicttarget, m_target);
      $display("group pc=%h valid=%b taken=%b lane0=%h", pc, admin2ib_instr_valid,
               admin2ib_predicttaken, admin2ib_instr[31:0]);
    end
    prev_valid = |admin2ib_instr_valid;

    acc   = m_asking && rdy;
    m_dlv = 0;
    if (resp_timer > 0) resp_timer--;
    if (acc) resp_timer = next_lat;
    if (rv) begin
      m_pc = rt & ~64'd3;
      m_want = 0;
      if (acc) begin
        m_flight = 1; m_drop = 1;
      end else if (m_flight && resp) begin
        m_flight = 0; m_drop = 0;
      end else if (m_flight) begin
        m_drop = 1;
      end
      m_asking = 0;
    end else begin
      if (m_asking) begin
        if (rdy) begin m_asking = 0; m_flight = 1; m_drop = 0; end
      end else if (m_flight) begin
        if (resp) begin
          m_flight = 0;
          if (!m_drop) model_deliver(data);
          m_drop = 0;
        end
      end else if (m_want || fi) begin
        m_asking = 1;
      end
      if (fi) m_want = 1;
      else if (acc) m_want = 0;
    end
    @(posedge clock);
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 1'b0, 64'd0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0;
    fetch_inst = 0; redirect_valid = 0; pc_index_ready = 0; icache_resp_valid = 0;
    #1;
    check("rst_pc_index_valid", pc_index_valid, 1'b0);
    check("rst_pc_index", pc_index, 64'b0);
    check("rst_instr_valid", admin2ib_instr_valid, 4'b0);
    check("rst_done", pc_operation_done, 1'b0);
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", admin2ib_instr, 128'b0);
    check("rst_predicttaken", admin2ib_predicttaken, 4'b0);
    check("rst_predicttarget", admin2ib_predicttarget, 128'b0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic fetch from the reset PC, response one cycle after accept.
    next_lat = 1;
    cycle(1, 0, 64'd0, 1); run(4, 1);

    // Unaligned redirect: group starts at word 2 of the line.
    cycle(0, 1, 64'h0000_0000_8000_0108, 1); cycle(1, 0, 64'd0, 1); run(4, 1);

    // Redirect while waiting; the stale response must be swallowed.
    next_lat = 4;
    cycle(1, 0, 64'd0, 1); run(2, 1);
    cycle(0, 1, 64'h0000_0000_0000_1000, 1); run(5, 1);
    cycle(1, 0, 64'd0, 1); run(6, 1);

    // Two requests while a group is in flight collapse into one follow-up.
    next_lat = 3;
    cycle(1, 0, 64'd0, 1); cycle(0, 0, 64'd0, 1);
    cycle(1, 0, 64'd0, 1); cycle(1, 0, 64'd0, 1); run(12, 1);

    // Icache stalls, then reset lands in the middle of the request.
    next_lat = 1;
    cycle(1, 0, 64'd0, 0); run(5, 0);
    do_reset();

`ifdef FETCH_BTFN_PREDICT_EN
    // Backward beq -16 in lane 1 at 0x80000004.
    use_fixed  = 1;
    fixed_data = {32'h0000_0013, 32'h0000_0013, 32'hFE00_08E3, 32'h0000_0013};
    cycle(0, 1, 64'h0000_0000_8000_0000, 1); cycle(1, 0, 64'd0, 1); run(4, 1);
    cycle(1, 0, 64'd0, 1); run(4, 1);
    use_fixed = 0;
`endif

    for (int k = 0; k < 3000; k++) begin
      next_lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            {$urandom(), $urandom()}, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
